ascon_core: RTL and testbench



---
 rtl/ascon_pkg.sv | 46 ++++
 rtl/ascon_round.sv | 57 +++++
 rtl/ascon_core.sv | 138 +++++++++++++
 tb/tb_ascon_core.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon-128a permutation engine: operation codes,
// FSM states, the initialization vector and the linear-layer rotations.
package ascon_pkg;

  typedef enum logic [2:0] {
    MODE_NONE        = 3'b000,
    MODE_INIT        = 3'b001,
    MODE_PERM_A      = 3'b010,
    MODE_PERM_B      = 3'b011,
    MODE_FINALIZE    = 3'b100,
    MODE_ABSORB      = 3'b101,
    MODE_ABSORB_LAST = 3'b110,
    MODE_DOMAIN_SEP  = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  localparam logic [63:0] IV       = 64'h80800c0800000000;
  localparam logic [3:0]  ROUNDS_A = 4'd12;
  localparam logic [3:0]  ROUNDS_B = 4'd8;

  localparam int ROT0_A = 19, ROT0_B = 28;
  localparam int ROT1_A = 61, ROT1_B = 39;
  localparam int ROT2_A = 1,  ROT2_B = 6;
  localparam int ROT3_A = 10, ROT3_B = 17;
  localparam int ROT4_A = 7,  ROT4_B = 41;

  // Rotate a 64-bit word right by a fixed amount.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int amt);
    return (x >> amt) | (x << (64 - amt));
  endfunction

  // Number of permutation rounds an operation runs.
  function automatic logic [3:0] mode_rounds(input mode_t m);
    case (m)
      MODE_INIT, MODE_PERM_A, MODE_FINALIZE: return ROUNDS_A;
      MODE_PERM_B, MODE_ABSORB:              return ROUNDS_B;
      default:                               return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box and
// linear diffusion layer. The round index selects the round constant.
module ascon_round
  import ascon_pkg::*;
(
  input  logic [63:0] x0_in,
  input  logic [63:0] x1_in,
  input  logic [63:0] x2_in,
  input  logic [63:0] x3_in,
  input  logic [63:0] x4_in,
  input  logic [3:0]  rnd,
  output logic [63:0] x0_out,
  output logic [63:0] x1_out,
  output logic [63:0] x2_out,
  output logic [63:0] x3_out,
  output logic [63:0] x4_out
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;

  // Constant addition, S-box layer and linear layer as one flat network.
  always_comb begin
    a0 = x0_in ^ x4_in;
    a1 = x1_in;
    a2 = x2_in ^ {56'h0, 4'hf - rnd, rnd} ^ x1_in;
    a3 = x3_in;
    a4 = x4_in ^ x3_in;

    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;

    b0 = a0 ^ t1;
    b1 = a1 ^ t2;
    b2 = a2 ^ t3;
    b3 = a3 ^ t4;
    b4 = a4 ^ t0;

    c0 = b0 ^ b4;
    c1 = b1 ^ b0;
    c2 = ~b2;
    c3 = b3 ^ b2;
    c4 = b4;

    x0_out = c0 ^ rotr(c0, ROT0_A) ^ rotr(c0, ROT0_B);
    x1_out = c1 ^ rotr(c1, ROT1_A) ^ rotr(c1, ROT1_B);
    x2_out = c2 ^ rotr(c2, ROT2_A) ^ rotr(c2, ROT2_B);
    x3_out = c3 ^ rotr(c3, ROT3_A) ^ rotr(c3, ROT3_B);
    x4_out = c4 ^ rotr(c4, ROT4_A) ^ rotr(c4, ROT4_B);
  end

endmodule

// File: rtl/ascon_core.sv
// Iterative Ascon-128a permutation engine. One round per clock; key, nonce
// and data XORs happen at the start edge and in the FINAL cycle.
module ascon_core
  import ascon_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] reg0_128b,
  input  logic [127:0] reg1_128b,
  input  logic [127:0] reg2_128b,
  input  logic [2:0]   operation_mode,
  input  logic         operation_ready,
  output logic [63:0]  S_0_reg,
  output logic [63:0]  S_1_reg,
  output logic [63:0]  S_2_reg,
  output logic [63:0]  S_3_reg,
  output logic [63:0]  S_4_reg,
  output logic         busy,
  output logic         done
);

  state_t      state, state_next;
  mode_t       mode_in, mode_q;
  logic        rdy_q, start, launch;
  logic [3:0]  rnd, n_rounds;
  logic [63:0] r0, r1, r2, r3, r4;
  logic [63:0] k_hi, k_lo, n_hi, n_lo, d_hi, d_lo;

  assign k_hi     = reg0_128b[127:64];
  assign k_lo     = reg0_128b[63:0];
  assign n_hi     = reg1_128b[127:64];
  assign n_lo     = reg1_128b[63:0];
  assign d_hi     = reg2_128b[127:64];
  assign d_lo     = reg2_128b[63:0];
  assign mode_in  = mode_t'(operation_mode);
  assign start    = operation_ready & ~rdy_q;
  assign launch   = (state == ST_IDLE) && start && (mode_in != MODE_NONE);
  assign n_rounds = mode_rounds(mode_in);

  ascon_round u_round (
    .x0_in  (S_0_reg),
    .x1_in  (S_1_reg),
    .x2_in  (S_2_reg),
    .x3_in  (S_3_reg),
    .x4_in  (S_4_reg),
    .rnd    (rnd),
    .x0_out (r0),
    .x1_out (r1),
    .x2_out (r2),
    .x3_out (r3),
    .x4_out (r4)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state: zero-round modes skip RUN, the last round index is 11.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (launch) state_next = (n_rounds != 4'd0) ? ST_RUN : ST_FINAL;
      ST_RUN:   if (rnd == 4'd11) state_next = ST_FINAL;
      ST_FINAL: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath: start-edge pre-op, one round per RUN cycle, post-op in FINAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_0_reg <= '0;
      S_1_reg <= '0;
      S_2_reg <= '0;
      S_3_reg <= '0;
      S_4_reg <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdy_q   <= 1'b0;
      rnd     <= 4'd0;
      mode_q  <= MODE_NONE;
    end else begin
      rdy_q <= operation_ready;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            mode_q <= mode_in;
            busy   <= 1'b1;
            rnd    <= 4'd12 - n_rounds;
            case (mode_in)
              MODE_INIT: begin
                S_0_reg <= IV;
                S_1_reg <= k_hi;
                S_2_reg <= k_lo;
                S_3_reg <= n_hi;
                S_4_reg <= n_lo;
              end
              MODE_FINALIZE: begin
                S_2_reg <= S_2_reg ^ k_hi;
                S_3_reg <= S_3_reg ^ k_lo;
              end
              MODE_ABSORB, MODE_ABSORB_LAST: begin
                S_0_reg <= S_0_reg ^ d_hi;
                S_1_reg <= S_1_reg ^ d_lo;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          S_0_reg <= r0;
          S_1_reg <= r1;
          S_2_reg <= r2;
          S_3_reg <= r3;
          S_4_reg <= r4;
          rnd     <= rnd + 4'd1;
        end
        ST_FINAL: begin
          busy <= 1'b0;
          done <= 1'b1;
          case (mode_q)
            MODE_INIT, MODE_FINALIZE: begin
              S_3_reg <= S_3_reg ^ k_hi;
              S_4_reg <= S_4_reg ^ k_lo;
            end
            MODE_DOMAIN_SEP: S_4_reg <= S_4_reg ^ 64'h1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_core.sv
// Self-checking bench for ascon_core against a table-driven Ascon model.
module tb_ascon_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] reg0_128b, reg1_128b, reg2_128b;
  logic [2:0]   operation_mode;
  logic         operation_ready;
  logic [63:0]  s0, s1, s2, s3, s4;
  logic         busy, done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] ms [5];
  logic [4:0]  sbox_tab [32];
  int          rot_a [5];
  int          rot_b [5];

  localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090a0b0c0d0e0f;

  ascon_core dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .reg0_128b       (reg0_128b),
    .reg1_128b       (reg1_128b),
    .reg2_128b       (reg2_128b),
    .operation_mode  (operation_mode),
    .operation_ready (operation_ready),
    .S_0_reg         (s0),
    .S_1_reg         (s1),
    .S_2_reg         (s2),
    .S_3_reg         (s3),
    .S_4_reg         (s4),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int a);
    logic [127:0] d;
    d = {x, x};
    return d[a +: 64];
  endfunction

  // Reference round: S-box applied column by column through its lookup table.
  task automatic model_round(input int i);
    logic [63:0] x [5];
    logic [4:0]  col, sub;
    for (int w = 0; w < 5; w++) x[w] = ms[w];
    x[2] = x[2] ^ 64'((15 - i) * 16 + i);
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      sub = sbox_tab[col];
      for (int w = 0; w < 5; w++) x[w][b] = sub[4 - w];
    end
    for (int w = 0; w < 5; w++) ms[w] = x[w] ^ ror(x[w], rot_a[w]) ^ ror(x[w], rot_b[w]);
  endtask

  // Reference operation: pre-op, the last nr rounds of the schedule, post-op.
  task automatic model_op(input logic [2:0] mode, input logic [127:0] key,
                          input logic [127:0] nonce, input logic [127:0] data,
                          output int nr);
    nr = 0;
    case (mode)
      3'd1: begin ms = '{64'h80800c0800000000, key[127:64], key[63:0], nonce[127:64], nonce[63:0]}; nr = 12; end
      3'd2: nr = 12;
      3'd3: nr = 8;
      3'd4: begin ms[2] ^= key[127:64]; ms[3] ^= key[63:0]; nr = 12; end
      3'd5: begin ms[0] ^= data[127:64]; ms[1] ^= data[63:0]; nr = 8; end
      3'd6: begin ms[0] ^= data[127:64]; ms[1] ^= data[63:0]; end
      default: ;
    endcase
    for (int i = 12 - nr; i < 12; i++) model_round(i);
    if (mode == 3'd1 || mode == 3'd4) begin
      ms[3] ^= key[127:64];
      ms[4] ^= key[63:0];
    end
    if (mode == 3'd7) ms[4] ^= 64'h1;
  endtask

  task automatic compareState(input string tag);
    checkOutput({tag, ".S_0"}, s0, ms[0]);
    checkOutput({tag, ".S_1"}, s1, ms[1]);
    checkOutput({tag, ".S_2"}, s2, ms[2]);
    checkOutput({tag, ".S_3"}, s3, ms[3]);
    checkOutput({tag, ".S_4"}, s4, ms[4]);
  endtask

  // One full operation: raise ready, time busy/done, compare state to model.
  task automatic applyStimulus(input string tag, input logic [2:0] mode, input logic [127:0] key,
                               input logic [127:0] nonce, input logic [127:0] data);
    int nr, exp_lat;
    logic seen;
    @(negedge clk);
    reg0_128b = key;
    reg1_128b = nonce;
    reg2_128b = data;
    operation_mode = mode;
    operation_ready = 1'b1;
    model_op(mode, key, nonce, data, nr);
    exp_lat = nr + 2;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput({tag, ".busy_start"}, 64'(busy), 64'(mode != 3'd0));
      if (done) begin
        checkOutput({tag, ".done_latency"}, 64'(k), 64'(exp_lat));
        checkOutput({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, ".done_seen"}, 64'(seen), 64'(mode != 3'd0));
    operation_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".done_one_cycle"}, 64'(done), 64'd0);
    compareState(tag);
  endtask

  initial begin
    logic [127:0] rk, rn, rd;
    int nr, cnt;
    logic seen;

    sbox_tab = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    rot_a = '{19, 61, 1, 10, 7};
    rot_b = '{28, 39, 6, 17, 41};
    for (int w = 0; w < 5; w++) ms[w] = '0;

    rst_n = 1'b0;
    reg0_128b = '0;
    reg1_128b = '0;
    reg2_128b = '0;
    operation_mode = 3'd0;
    operation_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    compareState("reset");
    rst_n = 1'b1;

    applyStimulus("domain_sep_from_zero", 3'd7, '0, '0, '0);
    applyStimulus("init_seq_key", 3'd1, KEY_SEQ, KEY_SEQ, '0);
    applyStimulus("perm_b", 3'd3, KEY_SEQ, KEY_SEQ, '0);
    applyStimulus("mode_none", 3'd0, KEY_SEQ, KEY_SEQ, 128'h1234);

    // Restart edge while busy in perm_a, offering domain_sep: must be ignored.
    @(negedge clk);
    operation_mode = 3'd2;
    operation_ready = 1'b1;
    model_op(3'd2, reg0_128b, reg1_128b, reg2_128b, nr);
    cnt = 0;
    seen = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 2) begin operation_ready = 1'b0; operation_mode = 3'd7; end
      if (k == 3) operation_ready = 1'b1;
      if (done) begin
        cnt++;
        if (!seen) checkOutput("ignored_start.done_latency", 64'(k), 64'(nr + 2));
        seen = 1'b1;
      end
    end
    checkOutput("ignored_start.done_count", 64'(cnt), 64'd1);
    checkOutput("ignored_start.busy_after", 64'(busy), 64'd0);
    compareState("ignored_start");
    operation_ready = 1'b0;

    // Asynchronous reset in the middle of an init run.
    @(negedge clk);
    operation_mode = 3'd1;
    operation_ready = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("abort.busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int w = 0; w < 5; w++) ms[w] = '0;
    checkOutput("abort.busy", 64'(busy), 64'd0);
    compareState("abort");
    operation_ready = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) cnt++;
    end
    checkOutput("abort.no_done", 64'(cnt), 64'd0);
    rst_n = 1'b1;
    applyStimulus("init_after_abort", 3'd1, KEY_SEQ, KEY_SEQ, '0);

    // Ascon-128a flow: init, AD block, domain sep, final PT block, finalize.
    rd = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus("enc.init", 3'd1, KEY_SEQ, KEY_SEQ, '0);
    applyStimulus("enc.ad", 3'd5, KEY_SEQ, KEY_SEQ, rd);
    applyStimulus("enc.dsep", 3'd7, KEY_SEQ, KEY_SEQ, '0);
    applyStimulus("enc.pt_last", 3'd6, KEY_SEQ, KEY_SEQ, {8'h80, 120'h0});
    applyStimulus("enc.finalize", 3'd4, KEY_SEQ, KEY_SEQ, '0);

    // Randomized operations on random operands.
    for (int t = 0; t < 16; t++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rn = {$urandom, $urandom, $urandom, $urandom};
      rd = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus($sformatf("rand%0d", t), 3'($urandom_range(0, 7)), rk, rn, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
